// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - Round-robin common data bus arbiter with per-source result FIFOs
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module cdb_arbiter #(
    parameter int N_SRC    = 3,
    parameter int ROB_ID_W = `ROB_SIZE_WIDTH,
    parameter int DEPTH    = 2,
    parameter int SRC_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      clear,
    input  logic [N_SRC-1:0]          req_valid,
    input  logic [N_SRC*ROB_ID_W-1:0] req_rob_id,
    input  logic [N_SRC*32-1:0]       req_value,
    output logic [N_SRC-1:0]          req_ready,
    output logic                      cdb_valid,
    output logic [ROB_ID_W-1:0]       cdb_rob_id,
    output logic [31:0]               cdb_value,
    output logic [SRC_W-1:0]          cdb_src,
    output logic [N_SRC-1:0]          fifo_busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ROB_ID_W-1:0] id_mem  [N_SRC][DEPTH];
    logic [31:0]         val_mem [N_SRC][DEPTH];
    logic [PTR_W-1:0]    wr_ptr  [N_SRC];
    logic [PTR_W-1:0]    rd_ptr  [N_SRC];
    logic [CNT_W-1:0]    count   [N_SRC];
    logic [SRC_W-1:0]    rr_ptr;
    logic [SRC_W-1:0]    rr_next;
    logic [SRC_W-1:0]    winner;
    logic                found;
    logic [N_SRC-1:0]    push;
    logic [N_SRC-1:0]    pop;
    int                  scan_idx;

    // Scan from rr_ptr upward, wrapping at N_SRC; first non-empty FIFO wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < N_SRC; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= N_SRC)
                scan_idx = scan_idx - N_SRC;
            if (!found && count[SRC_W'(scan_idx)] != '0) begin
                found  = 1'b1;
                winner = SRC_W'(scan_idx);
            end
        end
        rr_next = (winner == SRC_W'(N_SRC - 1)) ? '0 : winner + 1'b1;
    end

    always_comb begin
        req_ready = '0;
        push      = '0;
        pop       = '0;
        fifo_busy = '0;
        for (int i = 0; i < N_SRC; i++) begin
            req_ready[i] = rdy & ~clear & (count[i] != FULL);
            push[i]      = req_valid[i] & rdy & ~clear & (count[i] != FULL);
            pop[i]       = rdy & ~clear & found & (winner == SRC_W'(i));
            fifo_busy[i] = (count[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr     <= '0;
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_value  <= '0;
            cdb_src    <= '0;
        end else if (rdy) begin
            if (clear) begin
                for (int i = 0; i < N_SRC; i++) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                    count[i]  <= '0;
                end
                rr_ptr    <= '0;
                cdb_valid <= 1'b0;
            end else begin
                for (int i = 0; i < N_SRC; i++) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(push[i]);
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(pop[i]);
                    count[i]  <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
                end
                if (found) begin
                    cdb_valid  <= 1'b1;
                    cdb_rob_id <= id_mem[winner][rd_ptr[winner]];
                    cdb_value  <= val_mem[winner][rd_ptr[winner]];
                    cdb_src    <= winner;
                    rr_ptr     <= rr_next;
                end else begin
                    cdb_valid <= 1'b0;
                end
            end
        end
    end

    // Payload storage needs no reset: counts alone decide which slots are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) begin
                id_mem[i][wr_ptr[i]]  <= req_rob_id[i*ROB_ID_W +: ROB_ID_W];
                val_mem[i][wr_ptr[i]] <= req_value[i*32 +: 32];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - Scoreboard bench for cdb_arbiter against a queue-based model
module tb_cdb_arbiter;
    localparam int N     = 3;
    localparam int IDW   = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic             clear;
    logic [N-1:0]     req_valid;
    logic [N*IDW-1:0] req_rob_id;
    logic [N*32-1:0]  req_value;
    logic [N-1:0]     req_ready;
    logic             cdb_valid;
    logic [IDW-1:0]   cdb_rob_id;
    logic [31:0]      cdb_value;
    logic [1:0]       cdb_src;
    logic [N-1:0]     fifo_busy;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [IDW-1:0] id; logic [31:0] val; } ent_t;
    typedef struct { logic [IDW-1:0] id; logic [31:0] val; int src; } bc_t;

    ent_t       mq [N][$];
    bc_t        exp_q [$];
    int         m_rr;
    logic       m_valid;
    logic       edge_rdy;
    logic [N-1:0] m_acc;
    int         m_w;
    ent_t       m_e;
    bc_t        m_b;

    cdb_arbiter #(.N_SRC(N), .ROB_ID_W(IDW), .DEPTH(DEPTH), .SRC_W(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .req_valid(req_valid), .req_rob_id(req_rob_id), .req_value(req_value),
        .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
        .cdb_value(cdb_value), .cdb_src(cdb_src), .fifo_busy(fifo_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_busy();
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) b[i] = (mq[i].size() != 0);
        return b;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = rdy && !clear && (mq[i].size() < DEPTH);
        return r;
    endfunction

    // Reference model: per-source queues, a round-robin pointer, one grant per edge.
    always @(posedge clk) begin
        if (!rst) begin
            edge_rdy = rdy;
            if (rdy && clear) begin
                for (int i = 0; i < N; i++) mq[i].delete();
                m_rr    = 0;
                m_valid = 1'b0;
            end else if (rdy) begin
                for (int i = 0; i < N; i++) m_acc[i] = req_valid[i] && (mq[i].size() < DEPTH);
                m_w = -1;
                for (int k = 0; k < N; k++)
                    if (m_w < 0 && mq[(m_rr + k) % N].size() > 0) m_w = (m_rr + k) % N;
                if (m_w >= 0) begin
                    m_e = mq[m_w].pop_front();
                    exp_q.push_back('{id: m_e.id, val: m_e.val, src: m_w});
                    m_rr    = (m_w + 1) % N;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
                for (int i = 0; i < N; i++)
                    if (m_acc[i]) mq[i].push_back('{id: req_rob_id[i*IDW +: IDW], val: req_value[i*32 +: 32]});
            end
        end
    end

    // Monitor: a fresh broadcast is one seen after an edge where rdy was high.
    always @(negedge clk) begin
        if (!rst) begin
            check("cdb_valid", cdb_valid, m_valid);
            check("fifo_busy", fifo_busy, exp_busy());
            check("req_ready", req_ready, exp_ready());
            if (cdb_valid && edge_rdy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_broadcast: got id %0h src %0d expected none", cdb_rob_id, cdb_src);
                end else begin
                    m_b = exp_q.pop_front();
                    check("cdb_rob_id", cdb_rob_id, m_b.id);
                    check("cdb_value", cdb_value, m_b.val);
                    check("cdb_src", cdb_src, m_b.src);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic c, input logic [N-1:0] v,
                         input logic [N*IDW-1:0] ids, input logic [N*32-1:0] vals);
        rdy        = r;
        clear      = c;
        req_valid  = v;
        req_rob_id = ids;
        req_value  = vals;
        @(posedge clk);
        #1;
    endtask

    task automatic rdrive(input logic r, input logic c, input logic [N-1:0] v);
        drive(r, c, v, (N*IDW)'($urandom), {$urandom, $urandom, $urandom});
    endtask

    task automatic assert_rst();
        rst = 1'b1;
        for (int i = 0; i < N; i++) mq[i].delete();
        exp_q.delete();
        m_rr      = 0;
        m_valid   = 1'b0;
        edge_rdy  = 1'b0;
        rdy       = 1'b0;
        clear     = 1'b0;
        req_valid = '0;
    endtask

    task automatic do_reset();
        assert_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int   nid;
    logic acc0;
    logic v0;

    initial begin
        req_rob_id = '0;
        req_value  = '0;
        do_reset();
        check("rst_valid", cdb_valid, 1'b0);
        check("rst_rob_id", cdb_rob_id, 4'd0);
        check("rst_value", cdb_value, 32'd0);
        check("rst_src", cdb_src, 2'd0);
        check("rst_busy", fifo_busy, 3'b000);
        check("rst_ready", req_ready, 3'b000);

        // Single source latency
        drive(1, 0, 3'b001, {4'd0, 4'd0, 4'd5}, {32'd0, 32'd0, 32'h1234});
        check("single_no_bypass", cdb_valid, 1'b0);
        rdrive(1, 0, 3'b000);
        check("single_valid", cdb_valid, 1'b1);
        check("single_id", cdb_rob_id, 4'd5);
        check("single_value", cdb_value, 32'h1234);
        check("single_src", cdb_src, 2'd0);
        rdrive(1, 0, 3'b000);
        check("single_pulse", cdb_valid, 1'b0);

        // Simultaneous push from rr_ptr=0, then LSB and branch
        do_reset();
        drive(1, 0, 3'b111, {4'd3, 4'd2, 4'd1}, {32'h33, 32'h22, 32'h11});
        repeat (3) rdrive(1, 0, 3'b000);
        drive(1, 0, 3'b110, {4'd6, 4'd4, 4'd0}, {32'h66, 32'h44, 32'h0});
        rdrive(1, 0, 3'b000);
        check("lsb_first_src", cdb_src, 2'd1);
        check("lsb_first_id", cdb_rob_id, 4'd4);
        repeat (2) rdrive(1, 0, 3'b000);

        // Backpressure on ALU while LSB stays busy
        nid = 7;
        for (int k = 0; k < 10; k++) begin
            v0   = (nid <= 9);
            acc0 = v0 && (mq[0].size() < DEPTH);
            drive(1, 0, {1'b0, 1'b1, v0}, {4'd0, 4'(12 + k), 4'(nid)}, {32'd0, $urandom, 32'(nid)});
            if (acc0) nid++;
        end
        check("bp_all_accepted", nid, 10);
        repeat (6) rdrive(1, 0, 3'b000);

        // Flush with a simultaneous ALU push
        repeat (3) rdrive(1, 0, 3'b111);
        rdrive(1, 1, 3'b001);
        check("flush_valid", cdb_valid, 1'b0);
        check("flush_busy", fifo_busy, 3'b000);

        // Stall right after a grant of rob_id 3; rr_ptr is 0 after the flush
        drive(1, 0, 3'b111, {4'd11, 4'd10, 4'd3}, {32'hB, 32'hA, 32'h3});
        rdrive(1, 0, 3'b000);
        check("stall_grant_id", cdb_rob_id, 4'd3);
        for (int k = 0; k < 3; k++) begin
            rdrive(0, 0, 3'b111);
            check("stall_hold_valid", cdb_valid, 1'b1);
            check("stall_hold_id", cdb_rob_id, 4'd3);
        end
        rdrive(1, 0, 3'b000);
        check("resume_src", cdb_src, 2'd1);
        repeat (2) rdrive(1, 0, 3'b000);

        // Asynchronous reset mid-cycle with entries queued
        rdrive(1, 0, 3'b111);
        rdrive(1, 0, 3'b000);
        #3;
        assert_rst();
        #1;
        check("arst_valid", cdb_valid, 1'b0);
        check("arst_id", cdb_rob_id, 4'd0);
        check("arst_value", cdb_value, 32'd0);
        check("arst_src", cdb_src, 2'd0);
        check("arst_busy", fifo_busy, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 0, 3'b001, {4'd0, 4'd0, 4'd2}, {32'd0, 32'd0, 32'h2222});
        rdrive(1, 0, 3'b000);
        check("post_rst_valid", cdb_valid, 1'b1);
        check("post_rst_id", cdb_rob_id, 4'd2);

        // Randomized traffic with stalls and occasional flushes
        for (int k = 0; k < 400; k++)
            rdrive($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, 3'($urandom));
        repeat (10) rdrive(1, 0, 3'b000);
        check("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
